// File: rtl/priority_bit_extractor_pkg.sv
// rtl/priority_bit_extractor_pkg.sv - shared types and constants for the priority bit extractor
package priority_bit_extractor_pkg;

    // Two-state controller: waiting for a word, or walking its set bits
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    // Scan order selected per word by dir_i
    localparam logic DIR_LSB = 1'b0;
    localparam logic DIR_MSB = 1'b1;

endpackage

// File: rtl/priority_bit_extractor_priority_pick.sv
// rtl/priority_bit_extractor_priority_pick.sv - combinational pick of lowest or highest set bit
module priority_pick
    import priority_bit_extractor_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    input  logic             dir,
    output logic [WIDTH-1:0] onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Walk the vector from the far end toward the preferred end so the
    // last hit written is the one with the highest priority.
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = |vec;
        if (dir == DIR_LSB) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (vec[i]) begin
                    onehot    = '0;
                    onehot[i] = 1'b1;
                    idx       = IDX_W'(i);
                end
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (vec[i]) begin
                    onehot    = '0;
                    onehot[i] = 1'b1;
                    idx       = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/priority_bit_extractor.sv
// rtl/priority_bit_extractor.sv - emits one beat per set bit of each accepted word, in chosen order
module priority_bit_extractor
    import priority_bit_extractor_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH),
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             arst_n_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             data_val_i,
    input  logic             dir_i,
    output logic             data_ready_o,
    output logic [WIDTH-1:0] bit_onehot_o,
    output logic [IDX_W-1:0] bit_idx_o,
    output logic [CNT_W-1:0] bit_cnt_o,
    output logic             bit_empty_o,
    output logic             bit_last_o,
    output logic             bit_val_o,
    input  logic             bit_ready_i
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] residue;
    logic             dir_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] pop_in;

    logic [WIDTH-1:0] pick_onehot;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;

    logic             scan;
    logic             last_beat;
    logic             beat_hs;
    logic             accept;

    // Single picker on the residue; the bit it selects is the current beat
    priority_pick #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_pick (
        .vec    (residue),
        .dir    (dir_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Popcount of the incoming word, captured only at acceptance
    always_comb begin
        pop_in = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop_in = pop_in + CNT_W'(data_i[i]);
        end
    end

    // Current beat is last when nothing remains after removing the picked bit;
    // an empty word (residue 0) is therefore its own last beat.
    always_comb begin
        scan      = (state == ST_SCAN);
        last_beat = scan && ((residue & ~pick_onehot) == '0);
        beat_hs   = scan && bit_ready_i;
        accept    = data_val_i && data_ready_o;
    end

    // State register
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: a new word may be taken on the final beat handshake without a bubble
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (beat_hs && last_beat) begin
                    state_nxt = accept ? ST_SCAN : ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs: ready held low while reset is asserted; beat fields forced to 0 outside SCAN
    always_comb begin
        data_ready_o = arst_n_i && (!scan || (last_beat && bit_ready_i));
        bit_val_o    = scan;
        bit_onehot_o = scan ? pick_onehot : '0;
        bit_idx_o    = scan ? pick_idx : '0;
        bit_cnt_o    = scan ? cnt_q : '0;
        bit_empty_o  = scan && !pick_any;
        bit_last_o   = last_beat;
    end

    // Word datapath: load on acceptance, otherwise strip the delivered bit
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            residue <= '0;
            dir_q   <= DIR_LSB;
            cnt_q   <= '0;
        end else if (accept) begin
            residue <= data_i;
            dir_q   <= dir_i;
            cnt_q   <= pop_in;
        end else if (beat_hs) begin
            residue <= residue & ~pick_onehot;
        end
    end

endmodule

// File: tb/tb_priority_bit_extractor.sv
// tb/tb_priority_bit_extractor.sv - randomized self-checking bench for priority_bit_extractor
module tb_priority_bit_extractor;

    typedef struct packed {
        logic [7:0] onehot;
        logic [2:0] idx;
        logic [3:0] cnt;
        logic       empty;
        logic       last;
    } beat_t;

    logic       clk;
    logic       arst_n;
    logic [7:0] data;
    logic       data_val;
    logic       dir;
    logic       data_ready;
    logic [7:0] bit_onehot;
    logic [2:0] bit_idx;
    logic [3:0] bit_cnt;
    logic       bit_empty;
    logic       bit_last;
    logic       bit_val;
    logic       bit_ready;

    int n_checks = 0;
    int n_pass   = 0;
    beat_t exp_q[$];

    priority_bit_extractor dut (
        .clk_i        (clk),
        .arst_n_i     (arst_n),
        .data_i       (data),
        .data_val_i   (data_val),
        .dir_i        (dir),
        .data_ready_o (data_ready),
        .bit_onehot_o (bit_onehot),
        .bit_idx_o    (bit_idx),
        .bit_cnt_o    (bit_cnt),
        .bit_empty_o  (bit_empty),
        .bit_last_o   (bit_last),
        .bit_val_o    (bit_val),
        .bit_ready_i  (bit_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: list set-bit positions, reverse for MSB-first, one beat each
    function automatic void push_word(input logic [7:0] w, input logic d);
        int    pos[$];
        int    n;
        beat_t b;
        for (int i = 0; i < 8; i++) if (w[i]) pos.push_back(i);
        if (d) pos.reverse();
        n = pos.size();
        if (n == 0) begin
            b = '{onehot: 8'h00, idx: 3'd0, cnt: 4'd0, empty: 1'b1, last: 1'b1};
            exp_q.push_back(b);
        end else begin
            for (int k = 0; k < n; k++) begin
                b.onehot = 8'h00;
                b.onehot[pos[k]] = 1'b1;
                b.idx   = 3'(pos[k]);
                b.cnt   = 4'(n);
                b.empty = 1'b0;
                b.last  = (k == n - 1);
                exp_q.push_back(b);
            end
        end
    endfunction

    // One clock: drive after the edge, compare on the falling edge, advance model
    task automatic step(input logic [7:0] d, input logic v, input logic dr,
                        input logic rdy, output logic acc);
        logic  exp_ready;
        logic  hs;
        beat_t got;
        @(posedge clk);
        #1;
        data = d; data_val = v; dir = dr; bit_ready = rdy;
        @(negedge clk);
        got = {bit_onehot, bit_idx, bit_cnt, bit_empty, bit_last};
        if (exp_q.size() == 0) begin
            exp_ready = 1'b1;
            check("val_idle", 32'(bit_val), 32'd0);
            hs = 1'b0;
        end else begin
            exp_ready = (exp_q.size() == 1) && rdy;
            check("val_scan", 32'(bit_val), 32'd1);
            check("beat", 32'(got), 32'(exp_q[0]));
            hs = rdy;
        end
        check("ready", 32'(data_ready), 32'(exp_ready));
        acc = v && exp_ready;
        if (hs) void'(exp_q.pop_front());
        if (acc) push_word(d, dr);
    endtask

    // Hold a word valid until accepted, then let it drain
    task automatic send(input logic [7:0] w, input logic dr, input logic rdy);
        logic acc;
        int   guard;
        acc = 1'b0;
        guard = 0;
        while (!acc && guard < 50) begin
            step(w, 1'b1, dr, rdy, acc);
            guard++;
        end
        if (!acc) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        logic acc;
        int   guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            step(8'($urandom), 1'b0, 1'($urandom), 1'b1, acc);
            guard++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
        step(8'h00, 1'b0, 1'b0, 1'b1, acc);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2;
        arst_n = 1'b0;
        #1;
        check("rst_val", 32'(bit_val), 32'd0);
        check("rst_ready", 32'(data_ready), 32'd0);
        check("rst_outs", 32'({bit_onehot, bit_idx, bit_cnt, bit_empty, bit_last}), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        arst_n = 1'b1;
    endtask

    initial begin
        logic acc;
        int   words;
        int   guard;
        int   hs_cnt;
        arst_n = 1'b0; data = 8'h00; data_val = 1'b0; dir = 1'b0; bit_ready = 1'b0;
        #3;
        check("por_val", 32'(bit_val), 32'd0);
        check("por_ready", 32'(data_ready), 32'd0);
        check("por_outs", 32'({bit_onehot, bit_idx, bit_cnt, bit_empty, bit_last}), 32'd0);
        @(posedge clk);
        #1;
        arst_n = 1'b1;

        // Empty word
        send(8'h00, 1'b0, 1'b1);
        drain();
        // Mixed word both directions
        send(8'b1001_0100, 1'b0, 1'b1);
        drain();
        send(8'b1001_0100, 1'b1, 1'b1);
        drain();
        // All ones with ready toggling
        send(8'hFF, 1'b0, 1'b1);
        guard = 0;
        while (exp_q.size() != 0 && guard < 40) begin
            step(8'h00, 1'b0, 1'b0, 1'(guard % 2 == 1), acc);
            guard++;
        end
        drain();
        // Back-to-back words
        send(8'h81, 1'b0, 1'b1);
        send(8'h10, 1'b0, 1'b1);
        drain();
        // Reset mid-word
        send(8'hFF, 1'b0, 1'b1);
        hs_cnt = 0;
        while (hs_cnt < 1) begin
            step(8'h00, 1'b0, 1'b0, 1'b1, acc);
            hs_cnt++;
        end
        pulse_reset();
        send(8'h02, 1'b0, 1'b1);
        drain();

        // Random traffic
        words = 0;
        guard = 0;
        while (words < 1000 && guard < 40000) begin
            logic [7:0] w;
            case ($urandom_range(0, 7))
                0:       w = 8'h00;
                1:       w = 8'hFF;
                default: w = 8'($urandom);
            endcase
            step(w, 1'($urandom_range(0, 3) != 0), 1'($urandom),
                 1'($urandom_range(0, 3) != 0), acc);
            if (acc) words++;
            guard++;
        end
        if (words < 1000) check("random_timeout", 32'(words), 32'd1000);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/priority_bit_extractor.md
PRIORITY_BIT_EXTRACTOR -- requirements
Module: priority_bit_extractor

Interface
REQ-001 Parameter WIDTH, default 8, input word width; SHALL be >= 2.
REQ-002 Parameter IDX_W, default $clog2(WIDTH), bit-index width; SHALL NOT be overridden.
REQ-003 Parameter CNT_W, default $clog2(WIDTH+1), popcount width; SHALL NOT be overridden.
REQ-004 clk_i  input  1  single clock; all logic SHALL be rising-edge.
REQ-005 arst_n_i  input  1  reset; asynchronous, active-low.
REQ-006 data_i  input  WIDTH  word to scan.
REQ-007 data_val_i  input  1  data_i/dir_i valid.
REQ-008 dir_i  input  1  scan order for this word: 0 = LSB-first, 1 = MSB-first.
REQ-009 data_ready_o  output  1  block accepts a word this cycle.
REQ-010 bit_onehot_o  output  WIDTH  one-hot of current set bit; 0 for empty word.
REQ-011 bit_idx_o  output  IDX_W  index of current set bit; 0 for empty word.
REQ-012 bit_cnt_o  output  CNT_W  popcount of the word being scanned, constant over all its beats.
REQ-013 bit_empty_o  output  1  current word had no set bits.
REQ-014 bit_last_o  output  1  final beat of the current word.
REQ-015 bit_val_o  output  1  output beat valid.
REQ-016 bit_ready_i  input  1  downstream accepts beat.

Function
REQ-017 Word accepted on rising edge with data_val_i && data_ready_o; data_i, dir_i, popcount SHALL be registered.
REQ-018 FSM SHALL have two states, IDLE and SCAN; IDLE: data_ready_o=1, bit_val_o=0; SCAN: bit_val_o=1.
REQ-019 IDLE -> SCAN on acceptance; first beat SHALL appear the cycle after acceptance (latency 1).
REQ-020 In SCAN, beat SHALL present the lowest (dir 0) or highest (dir 1) set bit of the residue register.
REQ-021 On beat handshake (bit_val_o && bit_ready_i) that bit SHALL be cleared from residue; next beat next cycle.
REQ-022 Word with N>0 set bits SHALL produce exactly N beats in strict order; bit_last_o=1 only on the Nth.
REQ-023 Word of all zeros SHALL produce exactly one beat: onehot=0, idx=0, cnt=0, empty=1, last=1.
REQ-024 Handshake on last beat SHALL return to IDLE, unless a new word is accepted same cycle.
REQ-025 data_ready_o SHALL also be 1 in SCAN when bit_last_o && bit_ready_i (back-to-back); accepted word enters SCAN with no bubble.
REQ-026 While bit_val_o && !bit_ready_i all bit_* outputs SHALL hold stable.
REQ-027 data_i/dir_i with data_val_i=0, or while data_ready_o=0, SHALL be ignored.
REQ-028 All-ones word, WIDTH=8, dir 0: SHALL yield idx 0..7, cnt=8 on every beat.

Reset
REQ-029 arst_n_i low SHALL immediately force IDLE, residue=0, bit_val_o=0, data_ready_o=0, all bit_* outputs 0.
REQ-030 Reset mid-word SHALL discard the word without further beats; data_ready_o=1 first cycle after release.

Structure
REQ-031 Package priority_bit_extractor_pkg SHALL hold the state enum typedef and DIR_LSB/DIR_MSB constants.
REQ-032 Combinational sub-module priority_pick (WIDTH, dir -> onehot, idx, any) SHALL be instantiated once on the residue.
REQ-033 Popcount SHALL be computed at acceptance, not per beat.

Verification
REQ-034 8'b0000_0000, dir 0, ready=1 -> one beat: onehot 0, empty 1, last 1, cnt 0.
REQ-035 8'b1001_0100, dir 0 -> idx 2,4,7 on consecutive cycles, cnt 3, last on idx 7; dir 1 -> 7,4,2.
REQ-036 8'b1111_1111, dir 0, bit_ready_i toggling 1,0 -> 8 beats idx 0..7, outputs stable during stalls.
REQ-037 8'h81 then 8'h10 held valid -> second word accepted on last beat of first; beats 0,7,4 with no gap.
REQ-038 arst_n_i pulsed low after 2nd beat of 8'hFF -> bit_val_o 0 at once; next word 8'h02 -> single beat idx 1.
REQ-039 1000 random words, random dir and ready -> beat sequence matches software model of set-bit order.
